// File: rtl/load_align_unit.sv
`timescale 1ns/1ps
// load_align_unit
// Turns a byte-addressed RISC-V style load (LB/LH/LW/LBU/LHU) into one or two
// word reads from a fixed-latency data memory. It then extracts the addressed
// bytes and sign- or zero-extends them into a 32-bit result.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   req_valid   load request present
//   req_ready   high only while idle; accept = req_valid && req_ready
//   long_addr   byte address of the load, sampled on accept
//   load_type   funct3 code, sampled on accept
//   mem_read    word read strobe to data memory
//   mem_addr    word-aligned read address
//   mem_rdata   read data, valid the cycle after mem_read
//   read_value  extended load result, held until the next response
//   read_valid  one-cycle pulse marking read_value valid
//   load_error  flags an illegal load_type, only together with read_valid
module load_align_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] long_addr,
    input  logic [2:0]  load_type,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] read_value,
    output logic        read_valid,
    output logic        load_error
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        WAIT0,
        RD1,
        WAIT1,
        RESP
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] value_q, value_d;

    logic        typeLegal;
    logic        typeErr;
    logic        crossing;
    logic [1:0]  off;
    logic [63:0] wide;
    logic [31:0] raw;
    logic [31:0] result;
    logic [31:0] wordAddr;

    assign off      = addr_q[1:0];
    assign wordAddr = {addr_q[31:2], 2'b00};

    // Legality is judged on the live input at accept time.
    // It is judged again on the registered type when the response goes out.
    assign typeLegal = (load_type == LB) || (load_type == LH) || (load_type == LW) ||
                       (load_type == LBU) || (load_type == LHU);
    assign typeErr   = !((type_q == LB) || (type_q == LH) || (type_q == LW) ||
                         (type_q == LBU) || (type_q == LHU));

    // A halfword at offset 3, or a word at any nonzero offset, spills into the next word.
    assign crossing = ((type_q[1:0] == 2'b01) && (off == 2'd3)) ||
                      ((type_q[1:0] == 2'b10) && (off != 2'd0));

    // Little-endian extraction: shift the two-word window down by the byte offset.
    // For non-crossing loads only lo contributes to the bits that survive truncation.
    assign wide = {hi_q, lo_q} >> {off, 3'b000};
    assign raw  = wide[31:0];

    always_comb begin
        result = 32'h0;
        case (type_q)
            LB:      result = {{24{raw[7]}}, raw[7:0]};
            LH:      result = {{16{raw[15]}}, raw[15:0]};
            LW:      result = raw;
            LBU:     result = {24'h0, raw[7:0]};
            LHU:     result = {16'h0, raw[15:0]};
            default: result = 32'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            type_q  <= 3'b000;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
            value_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            value_q <= value_d;
        end
    end

    // Next-state and output logic.
    // read_value shows the fresh result during RESP and the registered copy afterwards.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        type_d     = type_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        value_d    = value_q;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_addr   = 32'h0;
        read_valid = 1'b0;
        load_error = 1'b0;
        read_value = value_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = long_addr;
                    type_d  = load_type;
                    state_d = typeLegal ? RD0 : RESP;
                end
            end
            RD0: begin
                mem_read = 1'b1;
                mem_addr = wordAddr;
                state_d  = WAIT0;
            end
            WAIT0: begin
                lo_d    = mem_rdata;
                state_d = crossing ? RD1 : RESP;
            end
            RD1: begin
                mem_read = 1'b1;
                mem_addr = wordAddr + 32'd4;
                state_d  = WAIT1;
            end
            WAIT1: begin
                hi_d    = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                read_valid = 1'b1;
                load_error = typeErr;
                read_value = result;
                value_d    = result;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
